// File: rtl/pmod_keypad_emulator.sv
`default_nettype none
// =====================================================================
// pmod_keypad_emulator : passive 4x4 PMOD keypad model driven by a
// valid/ready key-press command port; KEYEMU_BOUNCE_EN adds contact bounce.
// Revision: 1.0 - initial release
// =====================================================================
module pmod_keypad_emulator #(
   parameter int unsigned HOLD_W     = 24,
   parameter int unsigned BOUNCE_PER = 16,
   parameter int unsigned BOUNCE_N   = 3,
   parameter int unsigned GAP_CYC    = 256
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [3:0]        col,
   output logic [3:0]        row,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [3:0]        cmd_key,
   input  logic [HOLD_W-1:0] cmd_hold,
   output logic              key_down,
   output logic              busy,
   output logic              done
);

   if (HOLD_W < 1 || GAP_CYC < 1 || BOUNCE_PER < 1 || BOUNCE_N < 1 || BOUNCE_N > 255)
   begin : g_param_check
      $error("pmod_keypad_emulator: illegal parameter value");
   end

`ifdef KEYEMU_BOUNCE_EN
   typedef enum logic [2:0] {S_IDLE, S_BOUNCE_IN, S_HOLD, S_BOUNCE_OUT, S_GAP} state_t;
   localparam logic [HOLD_W-1:0] PER_LOAD = HOLD_W'(BOUNCE_PER - 1);
   localparam logic [8:0]        FLIPS    = 9'(2 * BOUNCE_N);
`else
   typedef enum logic [1:0] {S_IDLE, S_HOLD, S_GAP} state_t;
`endif
   localparam logic [HOLD_W-1:0] GAP_LOAD = HOLD_W'(GAP_CYC - 1);

   state_t            state_q, state_d;
   logic [HOLD_W-1:0] cnt_q, cnt_d;
   logic [3:0]        key_q, key_d;
   logic              contact_q, contact_d;
   logic              done_q, done_d;
`ifdef KEYEMU_BOUNCE_EN
   logic [HOLD_W-1:0] hold_q, hold_d;
   logic [8:0]        flips_q, flips_d;
`endif
   logic [HOLD_W-1:0] hold_eff;
   logic [1:0]        key_row, key_col;

   assign hold_eff  = (cmd_hold == '0) ? HOLD_W'(1) : cmd_hold;
   assign key_down  = contact_q;
   assign busy      = (state_q != S_IDLE);
   assign cmd_ready = (state_q == S_IDLE);
   assign done      = done_q;

   // Matrix position of the latched key.
   always_comb begin
      case (key_q)
         4'h1, 4'h2, 4'h3, 4'hA: key_row = 2'd0;
         4'h4, 4'h5, 4'h6, 4'hB: key_row = 2'd1;
         4'h7, 4'h8, 4'h9, 4'hC: key_row = 2'd2;
         default:                key_row = 2'd3;
      endcase
      case (key_q)
         4'h1, 4'h4, 4'h7, 4'h0: key_col = 2'd0;
         4'h2, 4'h5, 4'h8, 4'hF: key_col = 2'd1;
         4'h3, 4'h6, 4'h9, 4'hE: key_col = 2'd2;
         default:                key_col = 2'd3;
      endcase
   end

   // Closed contact shorts the key's column strobe onto its row line.
   always_comb begin
      row = 4'hF;
      if (contact_q && !col[key_col]) begin
         row[key_row] = 1'b0;
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = (cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
      key_d     = key_q;
      contact_d = contact_q;
      done_d    = 1'b0;
`ifdef KEYEMU_BOUNCE_EN
      hold_d    = hold_q;
      flips_d   = flips_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (cmd_valid) begin
               key_d     = cmd_key;
               contact_d = 1'b1;
`ifdef KEYEMU_BOUNCE_EN
               hold_d    = hold_eff;
               cnt_d     = PER_LOAD;
               flips_d   = '0;
               state_d   = S_BOUNCE_IN;
`else
               cnt_d     = hold_eff - 1'b1;
               state_d   = S_HOLD;
`endif
            end
         end
`ifdef KEYEMU_BOUNCE_EN
         S_BOUNCE_IN: begin
            if (cnt_q == '0) begin
               if (flips_q == FLIPS) begin
                  cnt_d   = hold_q - 1'b1;
                  state_d = S_HOLD;
               end else begin
                  contact_d = ~contact_q;
                  flips_d   = flips_q + 1'b1;
                  cnt_d     = PER_LOAD;
               end
            end
         end
`endif
         S_HOLD: begin
            if (cnt_q == '0) begin
               contact_d = 1'b0;
`ifdef KEYEMU_BOUNCE_EN
               cnt_d     = PER_LOAD;
               flips_d   = '0;
               state_d   = S_BOUNCE_OUT;
`else
               cnt_d     = GAP_LOAD;
               state_d   = S_GAP;
`endif
            end
         end
`ifdef KEYEMU_BOUNCE_EN
         S_BOUNCE_OUT: begin
            if (cnt_q == '0) begin
               if (flips_q == FLIPS) begin
                  cnt_d   = GAP_LOAD;
                  state_d = S_GAP;
               end else begin
                  contact_d = ~contact_q;
                  flips_d   = flips_q + 1'b1;
                  cnt_d     = PER_LOAD;
               end
            end
         end
`endif
         S_GAP: begin
            if (cnt_q == '0) begin
               done_d  = 1'b1;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         key_q     <= 4'h0;
         contact_q <= 1'b0;
         done_q    <= 1'b0;
`ifdef KEYEMU_BOUNCE_EN
         hold_q    <= '0;
         flips_q   <= '0;
`endif
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         key_q     <= key_d;
         contact_q <= contact_d;
         done_q    <= done_d;
`ifdef KEYEMU_BOUNCE_EN
         hold_q    <= hold_d;
         flips_q   <= flips_d;
`endif
      end
   end

endmodule
`default_nettype wire
